uart_tx_buffered: RTL

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_fifo.sv | 74 +++++++
 rtl/uart_tx_buffered.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry, idle line level.
// Used by the transmit side here and intended for reuse by the receive side.
// symbol_cycles() converts clock/baud into clock cycles per bit.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DataBits  = 8;
  localparam int FrameBits = 10;   // start + 8 data + stop (8N1)
  localparam logic IdleLevel = 1'b1;

  // Cycles per serial symbol; truncating division, so the line runs slightly fast.
  function automatic int symbol_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Generic synchronous FIFO holding bytes queued for transmission.
// Latency: a pushed entry is visible at pop_data one cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; both may occur together.
module uart_tx_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic [Width-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == (PtrW+1)'(Depth));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Next pointers/count; pointers wrap naturally because Depth is a power of two.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = push_data;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; stale entries are never read while count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a registered serial shifter.
// Latency: byte pushed in cycle N drives the start bit from cycle N+2 when idle.
// Backpressure: DataInReady low while the FIFO holds FifoDepth bytes.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200,
  parameter int FifoDepth = 4
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [7:0]                   DataIn,
  input  logic                         DataInValid,
  output logic                         DataInReady,
  output logic                         SOut,
  output logic                         Busy,
  output logic [$clog2(FifoDepth):0]   FifoCount
);

  localparam int SymbolEdgeTime = symbol_cycles(ClockFreq, BaudRate);
  localparam int BaudW = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;
  localparam int IdxW  = $clog2(DataBits);

  uart_state_e             state_q, state_d;
  logic [BaudW-1:0]        baud_q, baud_d;
  logic [IdxW-1:0]         bit_idx_q, bit_idx_d;
  logic [DataBits-1:0]     shift_q, shift_d;
  logic                    sout_q, sout_d;

  logic                    fifo_pop;
  logic [DataBits-1:0]     fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    symbol_end;

  uart_tx_fifo #(
    .Width (DataBits),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk       (Clock),
    .rst       (Reset),
    .push      (DataInValid),
    .push_data (DataIn),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (FifoCount)
  );

  assign DataInReady = !fifo_full;
  assign SOut        = sout_q;
  assign Busy        = (state_q != IDLE) || (FifoCount != '0);
  assign symbol_end  = (baud_q == BaudW'(SymbolEdgeTime - 1));

  // Next-state logic; SOut is computed for the upcoming state so the line is registered.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    sout_d    = sout_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        sout_d = IdleLevel;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = START;
          sout_d   = ~IdleLevel;
        end
      end
      START: begin
        if (symbol_end) begin
          state_d   = DATA;
          baud_d    = '0;
          bit_idx_d = '0;
          sout_d    = shift_q[0];
        end
      end
      DATA: begin
        if (symbol_end) begin
          baud_d = '0;
          if (bit_idx_q == IdxW'(DataBits - 1)) begin
            state_d = STOP;
            sout_d  = IdleLevel;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
            sout_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (symbol_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            // Back-to-back frame: straight into the next start bit, no idle symbol.
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = START;
            sout_d   = ~IdleLevel;
          end else begin
            state_d = IDLE;
            sout_d  = IdleLevel;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        sout_d  = IdleLevel;
      end
    endcase
  end

  // State register; reset aborts any frame in flight and returns the line to idle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      sout_q    <= IdleLevel;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      sout_q    <= sout_d;
    end
  end

endmodule
